// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, constants and address check for mem_ctrl_arbiter
package mem_ctrl_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int unsigned PORT_IF    = 0;
    localparam int unsigned PORT_D     = 1;
    localparam int unsigned WORD_BYTES = 4;

    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned num_words);
        return (addr[1:0] == 2'b00) && (addr < num_words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter, one-hot grant
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req_if,
    input  logic       i_req_d,
    output logic [1:0] o_gnt
);

    logic r_prefer_d;
    logic w_both;

    assign w_both = i_req_if & i_req_d;

    always_comb begin
        o_gnt = '0;
        if (w_both) begin
            o_gnt[PORT_D]  = r_prefer_d;
            o_gnt[PORT_IF] = ~r_prefer_d;
        end else begin
            o_gnt[PORT_IF] = i_req_if;
            o_gnt[PORT_D]  = i_req_d;
        end
    end

    // Pointer only moves when both ports contend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prefer_d <= 1'b0;
        end else if (w_both) begin
            r_prefer_d <= ~r_prefer_d;
        end
    end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// rtl/mem_ctrl_arbiter.sv - zero-fill sweep, then round-robin fetch/load-store access to one memory
module mem_ctrl_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 64,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data,
    output logic        init_done
);

    localparam int CW = $clog2(NUM_WORDS);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_addr_hold;
    logic            r_if_resp_valid;
    logic            r_if_good;
    logic            r_if_err;
    logic            r_d_resp_valid;
    logic            r_d_good;
    logic            r_d_err;

    logic            w_init;
    logic            w_serve;
    logic [1:0]      w_gnt;
    logic            w_gnt_any;
    logic [31:0]     w_gnt_addr;
    logic            w_ok;

    // The async reset also gates the combinational outputs so nothing leaks while it is held.
    assign w_init  = reset && (r_state == INIT);
    assign w_serve = reset && (r_state == SERVE);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req_if (if_req_valid & w_serve),
        .i_req_d  (d_req_valid & w_serve),
        .o_gnt    (w_gnt)
    );

    assign w_gnt_any  = |w_gnt;
    assign w_gnt_addr = w_gnt[PORT_D] ? d_addr : if_addr;
    assign w_ok       = addr_ok(w_gnt_addr, NUM_WORDS);

    assign if_req_ready = w_gnt[PORT_IF];
    assign d_req_ready  = w_gnt[PORT_D];
    assign init_done    = w_serve;

    always_comb begin
        mem_address = r_addr_hold;
        if (w_init) begin
            mem_address = 32'({r_cnt, 2'b00});
        end else if (w_gnt_any) begin
            mem_address = {w_gnt_addr[31:2], 2'b00};
        end
    end

    assign mem_write_data   = w_init ? 32'd0 : d_wdata;
    assign mem_write_enable = w_init | (w_gnt[PORT_D] & d_we & w_ok);

    assign if_resp_valid = r_if_resp_valid;
    assign if_resp_err   = r_if_err;
    assign if_resp_data  = r_if_good ? mem_read_data : 32'd0;
    assign d_resp_valid  = r_d_resp_valid;
    assign d_resp_err    = r_d_err;
    assign d_resp_data   = r_d_good ? mem_read_data : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= INIT_ON_RESET ? INIT : SERVE;
            r_cnt           <= '0;
            r_addr_hold     <= '0;
            r_if_resp_valid <= 1'b0;
            r_if_good       <= 1'b0;
            r_if_err        <= 1'b0;
            r_d_resp_valid  <= 1'b0;
            r_d_good        <= 1'b0;
            r_d_err         <= 1'b0;
        end else begin
            r_addr_hold <= mem_address;
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NUM_WORDS - 1)) begin
                        r_state <= SERVE;
                    end
                end
                SERVE: r_state <= SERVE;
                default: r_state <= INIT;
            endcase
            r_if_resp_valid <= w_gnt[PORT_IF];
            r_if_good       <= w_gnt[PORT_IF] & w_ok;
            r_if_err        <= w_gnt[PORT_IF] & ~w_ok;
            r_d_resp_valid  <= w_gnt[PORT_D];
            r_d_good        <= w_gnt[PORT_D] & w_ok & ~d_we;
            r_d_err         <= w_gnt[PORT_D] & ~w_ok;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb/tb_mem_ctrl_arbiter.sv - directed scoreboard bench for mem_ctrl_arbiter
module tb_mem_ctrl_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [31:0] if_addr, if_resp_data;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_err;
    logic [31:0] d_addr, d_wdata, d_resp_data;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, init_done;

    logic        z_if_req_valid, z_if_req_ready, z_if_resp_valid, z_if_resp_err;
    logic [31:0] z_if_addr, z_if_resp_data;
    logic        z_d_req_ready, z_d_resp_valid, z_d_resp_err;
    logic [31:0] z_d_resp_data, z_mem_address, z_mem_write_data, z_mem_read_data;
    logic        z_mem_write_enable, z_init_done;

    logic [31:0] mem  [64];
    logic [31:0] zmem [64];
    logic [31:0] refm [64];

    resp_t iq[$];
    resp_t dq[$];
    resp_t zq[$];

    int          checks   = 0;
    int          failures = 0;
    logic        prefer_d;
    logic        prev_if, prev_d;
    logic [31:0] last_addr;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(.NUM_WORDS(64), .INIT_ON_RESET(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .d_resp_err(d_resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data), .init_done(init_done)
    );

    mem_ctrl_arbiter #(.NUM_WORDS(64), .INIT_ON_RESET(1'b0)) u_dut0 (
        .clk(clk), .reset(reset),
        .if_req_valid(z_if_req_valid), .if_req_ready(z_if_req_ready), .if_addr(z_if_addr),
        .if_resp_valid(z_if_resp_valid), .if_resp_data(z_if_resp_data), .if_resp_err(z_if_resp_err),
        .d_req_valid(1'b0), .d_req_ready(z_d_req_ready), .d_addr(32'd0), .d_we(1'b0),
        .d_wdata(32'd0), .d_resp_valid(z_d_resp_valid), .d_resp_data(z_d_resp_data),
        .d_resp_err(z_d_resp_err), .mem_address(z_mem_address), .mem_write_data(z_mem_write_data),
        .mem_write_enable(z_mem_write_enable), .mem_read_data(z_mem_read_data), .init_done(z_init_done)
    );

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
        mem_read_data <= mem[mem_address[7:2]];
        if (z_mem_write_enable) zmem[z_mem_address[7:2]] <= z_mem_write_data;
        z_mem_read_data <= zmem[z_mem_address[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic good_addr(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd256);
    endfunction

    task automatic step(input logic ifv, input logic [31:0] ifa, input logic dv,
                        input logic [31:0] da, input logic dwe, input logic [31:0] dwd);
        logic        gi, gd, ok, exp_we;
        logic [31:0] exp_addr;
        resp_t       e;
        if_req_valid = ifv; if_addr = ifa;
        d_req_valid = dv; d_addr = da; d_we = dwe; d_wdata = dwd;
        @(negedge clk);
        check("init_done", init_done, 1);
        check("if_resp_valid", if_resp_valid, prev_if);
        check("d_resp_valid", d_resp_valid, prev_d);
        if (if_resp_valid && iq.size() > 0) begin
            e = iq.pop_front();
            check("if_resp_data", if_resp_data, e.data);
            check("if_resp_err", if_resp_err, e.err);
        end
        if (d_resp_valid && dq.size() > 0) begin
            e = dq.pop_front();
            check("d_resp_data", d_resp_data, e.data);
            check("d_resp_err", d_resp_err, e.err);
        end
        gi = ifv && (!dv || !prefer_d);
        gd = dv && (!ifv || prefer_d);
        if (ifv && dv) prefer_d = !prefer_d;
        check("if_req_ready", if_req_ready, gi);
        check("d_req_ready", d_req_ready, gd);
        exp_addr = last_addr;
        exp_we   = 1'b0;
        if (gi) begin
            ok = good_addr(ifa);
            exp_addr = ifa & 32'hFFFF_FFFC;
            e.data = ok ? refm[ifa[7:2]] : 32'd0;
            e.err  = !ok;
            iq.push_back(e);
        end
        if (gd) begin
            ok = good_addr(da);
            exp_addr = da & 32'hFFFF_FFFC;
            exp_we = dwe && ok;
            e.data = (ok && !dwe) ? refm[da[7:2]] : 32'd0;
            e.err  = !ok;
            dq.push_back(e);
            if (exp_we) begin
                check("mem_write_data", mem_write_data, dwd);
                refm[da[7:2]] = dwd;
            end
        end
        check("mem_address", mem_address, exp_addr);
        check("mem_write_enable", mem_write_enable, exp_we);
        last_addr = exp_addr;
        prev_if = gi;
        prev_d  = gd;
        @(posedge clk); #1;
    endtask

    initial begin
        resp_t e;
        reset = 1'b0;
        if_req_valid = 1'b1; if_addr = '0;
        d_req_valid = 1'b1; d_addr = '0; d_we = 1'b0; d_wdata = '0;
        z_if_req_valid = 1'b1; z_if_addr = '0;
        for (int i = 0; i < 64; i++) begin
            zmem[i] = 32'hA500_0000 | i;
            refm[i] = 32'd0;
        end
        prefer_d = 1'b0; prev_if = 1'b0; prev_d = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_ready", if_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        check("rst_we", mem_write_enable, 0);
        check("rst_init_done", init_done, 0);
        check("rst_if_resp_valid", if_resp_valid, 0);
        check("rst_d_resp_valid", d_resp_valid, 0);
        check("rst_z_ready", z_if_req_ready, 0);
        z_if_req_valid = 1'b0;

        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("init_we", mem_write_enable, 1);
            check("init_addr", mem_address, i * 4);
            check("init_wdata", mem_write_data, 0);
            check("init_if_ready", if_req_ready, 0);
            check("init_d_ready", d_req_ready, 0);
            check("init_done_low", init_done, 0);
            @(posedge clk); #1;
        end
        last_addr = 32'hFC;

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h10, 1, 32'hDEAD_BEEF);
        step(0, 0, 1, 32'h10, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 32'h0, 1, 32'h10, 0, 0);
        step(1, 32'h4, 1, 32'h10, 0, 0);
        step(1, 32'h8, 1, 32'h14, 1, 32'h1234_5678);
        step(1, 32'hC, 1, 32'h14, 0, 0);
        step(0, 0, 1, 32'h14, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 32'h102, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 1, 32'hCAFE_F00D);
        step(0, 0, 1, 32'h101, 0, 0);
        step(0, 0, 1, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);

        for (int k = 0; k < 5; k++) begin
            z_if_req_valid = (k < 3);
            z_if_addr = k * 4;
            @(negedge clk);
            check("z_init_done", z_init_done, 1);
            check("z_if_ready", z_if_req_ready, (k < 3));
            check("z_we", z_mem_write_enable, 0);
            check("z_resp_valid", z_if_resp_valid, (k >= 1 && k <= 3));
            if (z_if_resp_valid && zq.size() > 0) begin
                e = zq.pop_front();
                check("z_resp_data", z_if_resp_data, e.data);
                check("z_resp_err", z_if_resp_err, e.err);
            end
            if (k < 3) begin
                e.data = 32'hA500_0000 + k;
                e.err  = 1'b0;
                zq.push_back(e);
            end
            @(posedge clk); #1;
        end
        check("zq_drained", zq.size(), 0);

        step(0, 0, 1, 32'h10, 0, 0);
        reset = 1'b0;
        dq.delete();
        @(negedge clk);
        check("rstmid_d_resp_valid", d_resp_valid, 0);
        check("rstmid_we", mem_write_enable, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        d_req_valid = 1'b1;
        @(negedge clk);
        check("resweep_we", mem_write_enable, 1);
        check("resweep_addr0", mem_address, 0);
        check("resweep_d_ready", d_req_ready, 0);
        check("resweep_d_resp_valid", d_resp_valid, 0);
        check("resweep_init_done", init_done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("resweep_addr1", mem_address, 4);
        check("resweep_d_resp_valid2", d_resp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
